uart_rx: RTL and testbench

8N1 UART receiver, the receive end of the team's serial link (counterpart of the Hello World transmitter). It synchronises the asynchronous rx line, detects start bits and samples each bit at mid-bit. It presents each received byte through a one-entry holding register with a valid/ready handshake. Framing errors and overruns are flagged as single-cycle pulses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 34 +++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing
// and the receiver state encoding.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, byte out with
// valid/ready handshake and error pulses.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 overrun;

  modport slave (
    input  rx,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output overrun
  );

  modport master (
    output rx,
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  overrun
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input,
// reset to a configurable idle value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-entry holding
// register with valid/ready, framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.slave  bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic w_rx_s;
  logic w_fall;

  logic                 r_rx_d;
  rx_state_e            r_state;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_ferr;
  logic                 r_ovr;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.rx),
    .o_q (w_rx_s)
  );

  // Edge, not level: a line held low never restarts a frame.
  assign w_fall = r_rx_d & ~w_rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_d  <= 1'b1;
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_rx_d <= w_rx_s;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;

      if (r_valid && bus.rx_ready)
        r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_tick <= '0;
          r_bit  <= '0;
          if (w_fall) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (r_tick == TICK_HALF) begin
            r_tick <= '0;
            if (!w_rx_s) begin
              r_state <= DATA;
              r_bit   <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end

        DATA: begin
          if (r_tick == TICK_FULL) begin
            r_tick         <= '0;
            r_shift[r_bit] <= w_rx_s;
            if (r_bit == BIT_LAST)
              r_state <= STOP;
            else
              r_bit <= r_bit + BW'(1);
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end

        STOP: begin
          if (r_tick == TICK_FULL) begin
            r_tick  <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
            // Delivery wins over a same-cycle read.
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              if (r_valid && !bus.rx_ready)
                r_ovr <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_tick  <= '0;
          r_bit   <= '0;
        end
      endcase
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.rx_busy   = r_busy;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: scoreboarded frames, glitch, break,
// overrun and mid-frame reset sequences.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if ifc ();

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int   n_chk    = 0;
  int   n_fail   = 0;
  int   n_rx     = 0;
  int   n_ferr   = 0;
  int   n_ovr    = 0;
  int   busy_cnt = 0;
  bit   mon_en   = 1'b0;
  logic [7:0] sb_q[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.frame_err) n_ferr++;
      if (ifc.overrun)   n_ovr++;
      if (ifc.rx_busy)   busy_cnt++;
      if (mon_en && ifc.rx_valid && ifc.rx_ready) begin
        n_rx++;
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none",
                   ifc.rx_data);
        end else begin
          check("rx_byte", {24'h0, ifc.rx_data},
                {24'h0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    ifc.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 * CPB && sb_q.size() != 0; i++)
      @(negedge clk);
    check(name, sb_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t       vecs[12];
  string      hello;
  logic [7:0] hw[12];
  int         rx0, fe0, ov0;

  initial begin
    hello = "Hello World!";
    hw = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
           8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    for (int i = 0; i < 12; i++) begin
      vecs[i].din      = hello[i];
      vecs[i].stop     = 1'b1;
      vecs[i].exp_data = hw[i];
      vecs[i].exp_err  = 1'b0;
    end

    ifc.rx       = 1'b1;
    ifc.rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data",  {24'h0, ifc.rx_data}, 32'h0);
    check("rst_valid", {31'h0, ifc.rx_valid}, 32'h0);
    check("rst_busy",  {31'h0, ifc.rx_busy}, 32'h0);
    check("rst_ferr",  {31'h0, ifc.frame_err}, 32'h0);
    check("rst_ovr",   {31'h0, ifc.overrun}, 32'h0);

    // single 'H'
    ifc.rx_ready = 1'b1;
    mon_en = 1'b1;
    sb_q.push_back(8'h48);
    send_frame(8'h48, 1'b1);
    drain("drain_H");
    check("H_count", n_rx, 1);

    // back-to-back table
    rx0 = n_rx;
    for (int i = 0; i < 12; i++) begin
      sb_q.push_back(vecs[i].exp_data);
      send_frame(vecs[i].din, vecs[i].stop);
    end
    drain("drain_hello");
    check("hello_count", n_rx - rx0, 12);
    check("hello_ferr", n_ferr, 0);
    check("hello_ovr",  n_ovr, 0);

    // 4-clk low glitch
    repeat (CPB) @(negedge clk);
    rx0 = n_rx;
    busy_cnt = 0;
    ifc.rx = 1'b0;
    repeat (4) @(negedge clk);
    ifc.rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_busy_len",
          {31'h0, (busy_cnt >= 6 && busy_cnt <= 10)}, 32'h1);
    check("glitch_busy_seen", {31'h0, busy_cnt > 0}, 32'h1);
    check("glitch_rx",    n_rx - rx0, 0);
    check("glitch_valid", {31'h0, ifc.rx_valid}, 32'h0);
    check("glitch_ferr",  n_ferr, 0);

    // bad stop bit followed by a long break
    rx0 = n_rx;
    send_frame(8'h55, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    check("break_ferr",  n_ferr, 1);
    check("break_rx",    n_rx - rx0, 0);
    check("break_valid", {31'h0, ifc.rx_valid}, 32'h0);
    check("break_data",  {24'h0, ifc.rx_data}, 32'h21);
    check("break_busy",  {31'h0, ifc.rx_busy}, 32'h0);
    ifc.rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    sb_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    drain("drain_after_break");
    check("after_break_rx", n_rx - rx0, 1);

    // overrun with rx_ready low
    mon_en = 1'b0;
    ifc.rx_ready = 1'b0;
    ov0 = n_ovr;
    fe0 = n_ferr;
    send_frame(8'hA5, 1'b1);
    check("ovr_first_valid", {31'h0, ifc.rx_valid}, 32'h1);
    check("ovr_first_data",  {24'h0, ifc.rx_data}, 32'hA5);
    check("ovr_none_yet",    n_ovr - ov0, 0);
    send_frame(8'h3C, 1'b1);
    check("ovr_pulse",  n_ovr - ov0, 1);
    check("ovr_data",   {24'h0, ifc.rx_data}, 32'h3C);
    check("ovr_valid",  {31'h0, ifc.rx_valid}, 32'h1);
    check("ovr_ferr",   n_ferr - fe0, 0);
    ifc.rx_ready = 1'b1;
    @(negedge clk);
    ifc.rx_ready = 1'b0;
    check("ovr_cleared", {31'h0, ifc.rx_valid}, 32'h0);

    // reset in the middle of 0xF0, bit 4
    repeat (CPB) @(negedge clk);
    ifc.rx_ready = 1'b1;
    mon_en = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    ifc.rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("pre_rst_busy", {31'h0, ifc.rx_busy}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",  {31'h0, ifc.rx_busy}, 32'h0);
    check("arst_valid", {31'h0, ifc.rx_valid}, 32'h0);
    check("arst_data",  {24'h0, ifc.rx_data}, 32'h0);
    check("arst_ferr",  {31'h0, ifc.frame_err}, 32'h0);
    check("arst_ovr",   {31'h0, ifc.overrun}, 32'h0);
    check("arst_state", {30'h0, dut.r_state}, {30'h0, IDLE});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    rx0 = n_rx;
    sb_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    drain("drain_after_rst");
    check("after_rst_rx", n_rx - rx0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
